sr_reg_dump: RTL

Debug register dump engine that sits on the CPU's debug read port. On a start request it sweeps the debug register address from 0 to NREG-1 and captures the 32-bit value returned for each. It serialises the captured values into a byte-stream frame over a valid/ready handshake, normally feeding a UART transmitter. It is the reader side of the CPU's `regAddr`/`regData` debug interface, where address 0 returns the PC.

---
 rtl/sr_reg_dump.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sr_reg_dump.sv
// sr_reg_dump
// Debug register dump engine. On a start request it walks the CPU debug
// read port (regAddr/regData) from address 0 to NREG-1 and streams the
// captured values out as a byte frame over a valid/ready handshake:
//   0xA5, {reg[i][31:24], reg[i][23:16], reg[i][15:8], reg[i][7:0]} x NREG,
//   checksum (8-bit sum of all data bytes, header excluded).
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     dump request, only looked at in IDLE
//   regAddr   debug register address to the CPU (0 while idle)
//   regData   debug register data from the CPU (combinational in regAddr)
//   tx_data   stream byte
//   tx_valid  tx_data is valid
//   tx_ready  consumer accepts the byte
//   busy      a frame is in progress
//   done      one-cycle pulse in the first IDLE cycle after the last byte
module sr_reg_dump #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_SEND,
        S_CSUM
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        done_d;
    logic        xfer;

    // Stream outputs are decoded purely from registered state, so tx_ready
    // and regData never reach an output combinationally, and the byte on
    // offer cannot change until the state advances on a transfer.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[31:24];
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign xfer    = tx_valid & tx_ready;
    assign busy    = (state_q != S_IDLE);
    assign regAddr = (state_q == S_IDLE) ? 5'd0 : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    idx_d   = 5'd0;
                    csum_d  = 8'h00;
                end
            end
            S_HDR: begin
                if (xfer) state_d = S_LOAD;
            end
            S_LOAD: begin
                // Per-register snapshot; the CPU keeps running between loads.
                shift_d = regData;
                bcnt_d  = 2'd3;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    csum_d  = csum_q + shift_q[31:24];
                    shift_d = {shift_q[23:0], 8'h00};
                    if (bcnt_q != 2'd0) begin
                        bcnt_d = bcnt_q - 2'd1;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_CSUM;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            shift_q <= 32'h0;
            csum_q  <= 8'h00;
            bcnt_q  <= 2'd0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            bcnt_q  <= bcnt_d;
            done    <= done_d;
        end
    end

endmodule
